// File: rtl/led_display_pkg.sv
// ============================================================================
//  Module      : led_display_pkg
//  Description : Shared types and width helpers for the HUB75 scan scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_display_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4,
        WAIT    = 3'd5
    } scan_state_t;

    // Row address width; never narrower than one bit.
    function automatic int addr_width(input int num_row_pixels);
        return (num_row_pixels / 2 > 1) ? $clog2(num_row_pixels / 2) : 1;
    endfunction

    function automatic int plane_width(input int bit_depth);
        return (bit_depth > 1) ? $clog2(bit_depth) : 1;
    endfunction

    function automatic int on_timer_width(input int base_on_cycles, input int bit_depth);
        return $clog2(base_on_cycles << (bit_depth - 1)) + 1;
    endfunction

    // Binary-weighted on-time of a bit-plane.
    function automatic logic [31:0] on_time_cycles(input int base_on_cycles, input int plane);
        return 32'(base_on_cycles) << plane;
    endfunction

endpackage : led_display_pkg

`default_nettype wire

// File: rtl/led_display_on_timer.sv
// ============================================================================
//  Module      : led_display_on_timer
//  Description : Loadable down-counter; done is high while the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_on_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule : led_display_on_timer

`default_nettype wire

// File: rtl/led_display_scan_ctrl.sv
// ============================================================================
//  Module      : led_display_scan_ctrl
//  Description : Row/bit-plane BCM scan scheduler for a dual-scan HUB75 panel.
//                Define LED_SCAN_STATS_EN to build the frame/stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_display_scan_ctrl
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int BIT_DEPTH      = 4,
    parameter int BASE_ON_CYCLES = 64,
    parameter int BLANK_CYCLES   = 4,
    parameter int LATCH_CYCLES   = 1,
    parameter int ADDR_W         = addr_width(NUM_ROW_PIXELS),
    parameter int PL_W           = plane_width(BIT_DEPTH)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              enable_in,
    output logic              shift_req_out,
    output logic [ADDR_W-1:0] shift_row_out,
    output logic [PL_W-1:0]   shift_plane_out,
    input  logic              shift_done_in,
    output logic              latch_out,
    output logic              blank_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              frame_start_out,
    output logic              busy_out,
    output logic [15:0]       frame_count_out,
    output logic [15:0]       stall_count_out
);

    localparam int c_scan_rows = NUM_ROW_PIXELS / 2;
    localparam int c_on_w      = on_timer_width(BASE_ON_CYCLES, BIT_DEPTH);
    localparam int c_blank_w   = $clog2(BLANK_CYCLES) + 1;
    localparam int c_latch_w   = $clog2(LATCH_CYCLES) + 1;

    // Clock frequency and column count are informational only.
    if (SYS_CLK_FREQ <= 0 || NUM_COL_PIXELS <= 0) begin : g_param_guard
    end

    scan_state_t       r_state;
    scan_state_t       w_next;
    logic [ADDR_W-1:0] r_row;
    logic [PL_W-1:0]   r_plane;
    logic [ADDR_W-1:0] r_disp_row;
    logic [PL_W-1:0]   r_disp_plane;
    logic [ADDR_W-1:0] w_nxt_row;
    logic [PL_W-1:0]   w_nxt_plane;
    logic              r_shift_req;
    logic              r_pf_issued;
    logic              r_pf_done;
    logic              r_frame_start;
    logic              w_done_ok;
    logic              w_pf_ok;
    logic              w_on_done;
    logic              w_blank_done;
    logic              w_latch_done;
    logic              w_enter_blank;
    logic              w_enter_latch;
    logic              w_enter_display;
    logic              w_prefetch;

    assign w_done_ok       = r_shift_req & shift_done_in;
    assign w_pf_ok         = r_pf_done | w_done_ok;
    assign w_enter_blank   = (w_next == BLANK) && (r_state != BLANK);
    assign w_enter_latch   = (w_next == LATCH) && (r_state != LATCH);
    assign w_enter_display = (w_next == DISPLAY) && (r_state != DISPLAY);
    assign w_prefetch      = w_enter_display && enable_in;

    // Plane inner, row outer.
    always_comb begin
        w_nxt_row   = r_row;
        w_nxt_plane = r_plane + 1'b1;
        if (r_plane == PL_W'(BIT_DEPTH - 1)) begin
            w_nxt_plane = '0;
            w_nxt_row   = (r_row == ADDR_W'(c_scan_rows - 1)) ? '0 : r_row + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable_in)    w_next = SHIFT;
            SHIFT:   if (w_done_ok)    w_next = BLANK;
            BLANK:   if (w_blank_done) w_next = LATCH;
            LATCH:   if (w_latch_done) w_next = DISPLAY;
            DISPLAY: begin
                if (w_on_done) begin
                    if (!w_pf_ok)                      w_next = WAIT;
                    else if (enable_in && r_pf_issued) w_next = BLANK;
                    else                               w_next = IDLE;
                end
            end
            WAIT:    if (w_done_ok)    w_next = enable_in ? BLANK : IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_plane       <= '0;
            r_disp_row    <= '0;
            r_disp_plane  <= '0;
            r_shift_req   <= 1'b0;
            r_pf_issued   <= 1'b0;
            r_pf_done     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_done_ok) begin
                r_shift_req <= 1'b0;
            end
            if ((r_state == IDLE && enable_in) || w_prefetch) begin
                r_shift_req <= 1'b1;
            end

            // The pointer always names the step being (or last) shifted.
            if (w_prefetch) begin
                r_row   <= w_nxt_row;
                r_plane <= w_nxt_plane;
            end

            r_frame_start <= 1'b0;
            if (w_enter_latch) begin
                r_disp_row    <= r_row;
                r_disp_plane  <= r_plane;
                r_frame_start <= (r_row == '0) && (r_plane == '0);
            end

            // Without a prefetch there is nothing to wait for.
            if (w_enter_display) begin
                r_pf_issued <= enable_in;
                r_pf_done   <= ~enable_in;
            end else if (r_state == DISPLAY && w_done_ok) begin
                r_pf_done <= 1'b1;
            end
        end
    end

    led_display_on_timer #(.WIDTH(c_on_w)) u_on_timer (
        .clk     (clk_in),
        .rst     (reset_in),
        .i_load  (w_enter_display),
        .i_value (c_on_w'(on_time_cycles(BASE_ON_CYCLES, int'(r_disp_plane)) - 32'd1)),
        .o_done  (w_on_done)
    );

    led_display_on_timer #(.WIDTH(c_blank_w)) u_blank_timer (
        .clk     (clk_in),
        .rst     (reset_in),
        .i_load  (w_enter_blank),
        .i_value (c_blank_w'(BLANK_CYCLES - 1)),
        .o_done  (w_blank_done)
    );

    led_display_on_timer #(.WIDTH(c_latch_w)) u_latch_timer (
        .clk     (clk_in),
        .rst     (reset_in),
        .i_load  (w_enter_latch),
        .i_value (c_latch_w'(LATCH_CYCLES - 1)),
        .o_done  (w_latch_done)
    );

    assign shift_req_out   = r_shift_req;
    assign shift_row_out   = r_row;
    assign shift_plane_out = r_plane;
    assign latch_out       = (r_state == LATCH);
    assign blank_out       = (r_state != DISPLAY);
    assign addr_out        = r_disp_row;
    assign frame_start_out = r_frame_start;
    assign busy_out        = (r_state != IDLE);

`ifdef LED_SCAN_STATS_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_stall_count;
    logic        r_first_seen;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_frame_count <= '0;
            r_stall_count <= '0;
            r_first_seen  <= 1'b0;
        end else begin
            if (r_frame_start) begin
                r_first_seen <= 1'b1;
                if (r_first_seen) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end
            if (r_state == WAIT && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign frame_count_out = r_frame_count;
    assign stall_count_out = r_stall_count;
`else
    assign frame_count_out = '0;
    assign stall_count_out = '0;
`endif

endmodule : led_display_scan_ctrl

`default_nettype wire

// File: tb/tb_led_display_scan_ctrl.sv
// ============================================================================
//  Module      : tb_led_display_scan_ctrl
//  Description : Directed self-checking bench for led_display_scan_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_display_scan_ctrl;

    localparam int c_addr_w  = 1;
    localparam int c_pl_w    = 1;
    localparam int c_phy_dly = 3;
`ifdef LED_SCAN_STATS_EN
    localparam int c_stats = 1;
`else
    localparam int c_stats = 0;
`endif

    logic                clk_in = 1'b0;
    logic                reset_in;
    logic                enable_in;
    logic                shift_req_out;
    logic [c_addr_w-1:0] shift_row_out;
    logic [c_pl_w-1:0]   shift_plane_out;
    logic                shift_done_in;
    logic                latch_out;
    logic                blank_out;
    logic [c_addr_w-1:0] addr_out;
    logic                frame_start_out;
    logic                busy_out;
    logic [15:0]         frame_count_out;
    logic [15:0]         stall_count_out;

    logic phy_done;
    logic man_done;
    logic phy_en;
    logic slow_mode;
    logic slow_used;

    logic [1:0] req_log[$];
    int         lo_log[$];
    int         hi_log[$];
    int         fs_log[$];
    int         stab_err;

    int n_vec  = 0;
    int n_miss = 0;

    assign shift_done_in = phy_done | man_done;

    always #5 clk_in = ~clk_in;

    led_display_scan_ctrl #(
        .NUM_ROW_PIXELS (4),
        .BIT_DEPTH      (2),
        .BASE_ON_CYCLES (4),
        .BLANK_CYCLES   (2),
        .LATCH_CYCLES   (1)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .enable_in       (enable_in),
        .shift_req_out   (shift_req_out),
        .shift_row_out   (shift_row_out),
        .shift_plane_out (shift_plane_out),
        .shift_done_in   (shift_done_in),
        .latch_out       (latch_out),
        .blank_out       (blank_out),
        .addr_out        (addr_out),
        .frame_start_out (frame_start_out),
        .busy_out        (busy_out),
        .frame_count_out (frame_count_out),
        .stall_count_out (stall_count_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PHY model: done arrives in cycle (delay-1) counted from the req's first cycle.
    initial begin : phy
        int dly;
        phy_done  = 1'b0;
        slow_used = 1'b0;
        forever begin
            @(posedge clk_in); #1;
            if (phy_en && shift_req_out) begin
                dly = c_phy_dly;
                if (slow_mode && !slow_used && shift_plane_out == 1'b1) begin
                    dly       = 20;
                    slow_used = 1'b1;
                end
                repeat (dly - 1) @(posedge clk_in);
                #1 phy_done = 1'b1;
                @(posedge clk_in); #1 phy_done = 1'b0;
            end
        end
    end

    initial begin : mon
        int         lo_run;
        int         hi_run;
        int         latch_cnt;
        logic       req_q;
        logic       lat_q;
        logic [1:0] req_val;
        lo_run = 0; hi_run = 0; latch_cnt = 0;
        req_q = 1'b0; lat_q = 1'b0; req_val = '0; stab_err = 0;
        forever begin
            @(posedge clk_in); #1;
            if (shift_req_out && !req_q) begin
                req_val = {shift_row_out, shift_plane_out};
                req_log.push_back(req_val);
            end else if (shift_req_out && {shift_row_out, shift_plane_out} != req_val) begin
                stab_err++;
            end
            req_q = shift_req_out;
            if (!blank_out) begin
                if (hi_run > 0) hi_log.push_back(hi_run);
                hi_run = 0;
                lo_run++;
            end else begin
                if (lo_run > 0) lo_log.push_back(lo_run);
                lo_run = 0;
                hi_run++;
            end
            if (latch_out && !lat_q) begin
                if (frame_start_out) fs_log.push_back(latch_cnt);
                latch_cnt++;
            end
            lat_q = latch_out;
        end
    end

    initial begin : main
        int rb;
        int lb;
        int hb;
        int hmax;
        logic found;
        reset_in  = 1'b1;
        enable_in = 1'b0;
        man_done  = 1'b0;
        phy_en    = 1'b1;
        slow_mode = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_blank", blank_out, 1);
        check("rst_latch", latch_out, 0);
        check("rst_req", shift_req_out, 0);
        check("rst_addr", addr_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_fstart", frame_start_out, 0);

        // 2: normal scan
        enable_in = 1'b1;
        for (int i = 0; i < 300 && fs_log.size() < 2; i++) @(negedge clk_in);
        check("t2_two_frames", fs_log.size() >= 2, 1);
        repeat (2) @(negedge clk_in);
        check("t2_frame_count", frame_count_out, (c_stats != 0) ? 1 : 0);
        check("t2_req0", req_log[0], 2'b00);
        check("t2_req1", req_log[1], 2'b01);
        check("t2_req2", req_log[2], 2'b10);
        check("t2_req3", req_log[3], 2'b11);
        check("t2_req4", req_log[4], 2'b00);
        check("t2_on0", lo_log[0], 4);
        check("t2_on1", lo_log[1], 8);
        check("t2_on2", lo_log[2], 4);
        check("t2_on3", lo_log[3], 8);
        check("t2_fs_first", fs_log[0], 0);
        check("t2_fs_period", fs_log[1] - fs_log[0], 4);
        check("t2_no_stall", stall_count_out, 0);

        // 3: one slow prefetch during a plane-0 display
        hb = hi_log.size();
        slow_mode = 1'b1;
        repeat (100) @(negedge clk_in);
        hmax = 0;
        for (int i = hb; i < hi_log.size(); i++) if (hi_log[i] > hmax) hmax = hi_log[i];
        check("t3_dark_gap", hmax, 19);
        check("t3_stall_count", stall_count_out, (c_stats != 0) ? 16 : 0);

        // 4: enable drop during display of (1,0)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_in);
            found = !blank_out && addr_out == 1'b1 && shift_row_out == 1'b1 && shift_plane_out == 1'b1;
        end
        check("t4_found_r1p0", found, 1);
        enable_in = 1'b0;
        rb = req_log.size();
        lb = lo_log.size();
        repeat (30) @(negedge clk_in);
        check("t4_idle", busy_out, 0);
        check("t4_blank", blank_out, 1);
        check("t4_req_low", shift_req_out, 0);
        check("t4_no_new_req", req_log.size(), rb);
        check("t4_display_done", (lo_log.size() > lb) ? lo_log[lb] : 0, 4);
        check("t4_ptr_held", {shift_row_out, shift_plane_out}, 2'b11);
        enable_in = 1'b1;
        for (int i = 0; i < 50 && req_log.size() <= rb; i++) @(negedge clk_in);
        check("t4_resume_req", (req_log.size() > rb) ? req_log[rb] : 2'bxx, 2'b11);

        // 5: reset mid-display
        for (int i = 0; i < 100 && blank_out; i++) @(negedge clk_in);
        check("t5_in_display", blank_out, 0);
        reset_in = 1'b1;
        #1;
        check("t5_blank", blank_out, 1);
        check("t5_latch", latch_out, 0);
        check("t5_req", shift_req_out, 0);
        check("t5_addr", addr_out, 0);
        check("t5_busy", busy_out, 0);
        check("t5_ptr", {shift_row_out, shift_plane_out}, 2'b00);
        check("t5_stall_clr", stall_count_out, 0);
        check("t5_frame_clr", frame_count_out, 0);
        enable_in = 1'b0;
        phy_en    = 1'b0;
        repeat (30) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);

        // 6: stray done while no request is pending
        man_done = 1'b1;
        @(negedge clk_in);
        man_done = 1'b0;
        repeat (2) @(negedge clk_in);
        check("t6_stray_idle", busy_out, 0);
        rb = req_log.size();
        enable_in = 1'b1;
        repeat (8) @(negedge clk_in);
        check("t6_first_req", (req_log.size() > rb) ? req_log[rb] : 2'bxx, 2'b00);
        check("t6_req_held", shift_req_out, 1);
        check("t6_still_shift", blank_out, 1);
        check("t6_no_latch", latch_out, 0);
        man_done = 1'b1;
        @(negedge clk_in);
        man_done = 1'b0;
        check("t6_req_drop", shift_req_out, 0);
        repeat (3) @(negedge clk_in);
        check("t6_display", blank_out, 0);
        check("t6_addr", addr_out, 0);

        check("req_stable", stab_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_led_display_scan_ctrl

`default_nettype wire
